// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
//
// Fetch-stage control FSM. It sequences one AXI4-Lite instruction read per
// instruction, hands the fetched word to decode, and holds the PC while a
// control transfer (JAL/JALR/BRANCH) waits for resolution in execute.
// It drives the state / pc_we / inst_we strobes of the fetch register that
// holds pc/inst.
//
// Optional feature macro: FETCH_PERF_EN
//   defined   : perf_fetch_o counts inst_we_o pulses and perf_stall_o counts
//               cycles in WAIT_ARREADY/WAIT_RVALID (both wrap mod 2^PERF_W)
//   undefined : no counter registers; both perf outputs tie to zero
//
// Ports:
//   clock, reset          clock; asynchronous active-low reset
//   firing                start pulse, honoured only in IDLE
//   pc_i, inst_i          current PC / latched instruction from fetch register
//   arvalid_o, arready_i  AXI AR handshake; araddr_o = pc_i
//   rvalid_i, rready_o    AXI R handshake; rresp_i = read response
//   valid_o, ready_i      instruction hand-off to decode
//   branch_valid_i        execute resolved the pending control transfer
//   state_o               FSM state encoding to the fetch register
//   pc_we_o, inst_we_o    PC += 4 strobe / instruction latch strobe
//   bus_err_o             sticky bus error, cleared only by reset
//   perf_fetch_o          completed fetches
//   perf_stall_o          cycles waiting on the bus
// -----------------------------------------------------------------------------
module fetch_ctrl #(
  parameter int PERF_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              firing,
  input  logic [31:0]       pc_i,
  input  logic [31:0]       inst_i,
  output logic              arvalid_o,
  input  logic              arready_i,
  output logic [31:0]       araddr_o,
  input  logic              rvalid_i,
  output logic              rready_o,
  input  logic [1:0]        rresp_i,
  output logic              valid_o,
  input  logic              ready_i,
  input  logic              branch_valid_i,
  output logic [2:0]        state_o,
  output logic              pc_we_o,
  output logic              inst_we_o,
  output logic              bus_err_o,
  output logic [PERF_W-1:0] perf_fetch_o,
  output logic [PERF_W-1:0] perf_stall_o
);

  // Encodings are decoded by the fetch register and must not change.
  typedef enum logic [2:0] {
    IDLE         = 3'b000,
    WAIT_READY   = 3'b001,
    WAIT_ARREADY = 3'b010,
    WAIT_RVALID  = 3'b011,
    WAIT_BRANCH  = 3'b100
  } state_t;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Opcodes whose successor PC is decided by execute, not by PC += 4.
  function automatic logic is_ctrl_xfer(input logic [6:0] opcode);
    is_ctrl_xfer = (opcode == OP_JAL) || (opcode == OP_JALR) || (opcode == OP_BRANCH);
  endfunction

  state_t r_state;
  state_t w_next_state;
  logic   r_bus_err;
  logic   w_bus_err_set;
  logic   w_arvalid;
  logic   w_rready;
  logic   w_valid;
  logic   w_pc_we;
  logic   w_inst_we;

  // Only the opcode field steers the FSM; the rest of the word is decode's.
  logic   w_unused_inst;
  assign w_unused_inst = ^inst_i[31:7];

  // State register and sticky bus-error flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_bus_err <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_bus_err_set) begin
        r_bus_err <= 1'b1;
      end
    end
  end

  // Next-state and strobe decode; every strobe defaults low.
  always_comb begin
    w_next_state  = r_state;
    w_arvalid     = 1'b0;
    w_rready      = 1'b0;
    w_valid       = 1'b0;
    w_pc_we       = 1'b0;
    w_inst_we     = 1'b0;
    w_bus_err_set = 1'b0;
    case (r_state)
      IDLE: begin
        if (firing) begin
          w_next_state = WAIT_ARREADY;
        end else begin
          w_next_state = IDLE;
        end
      end
      WAIT_ARREADY: begin
        w_arvalid = 1'b1;
        if (arready_i) begin
          w_next_state = WAIT_RVALID;
        end else begin
          w_next_state = WAIT_ARREADY;
        end
      end
      WAIT_RVALID: begin
        w_rready = 1'b1;
        if (rvalid_i) begin
          if (rresp_i == 2'b00) begin
            w_inst_we    = 1'b1;
            w_next_state = WAIT_READY;
          end else begin
            // Errored read: drop the word and stop until the next firing.
            w_bus_err_set = 1'b1;
            w_next_state  = IDLE;
          end
        end else begin
          w_next_state = WAIT_RVALID;
        end
      end
      WAIT_READY: begin
        w_valid = 1'b1;
        if (ready_i) begin
          if (is_ctrl_xfer(inst_i[6:0])) begin
            // Execute owns the next PC; hold it here.
            w_next_state = WAIT_BRANCH;
          end else begin
            w_pc_we      = 1'b1;
            w_next_state = WAIT_ARREADY;
          end
        end else begin
          w_next_state = WAIT_READY;
        end
      end
      WAIT_BRANCH: begin
        if (branch_valid_i) begin
          w_next_state = WAIT_ARREADY;
        end else begin
          w_next_state = WAIT_BRANCH;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  assign state_o   = r_state;
  assign araddr_o  = pc_i;
  assign arvalid_o = w_arvalid;
  assign rready_o  = w_rready;
  assign valid_o   = w_valid;
  assign pc_we_o   = w_pc_we;
  assign inst_we_o = w_inst_we;
  assign bus_err_o = r_bus_err;

`ifdef FETCH_PERF_EN
  logic [PERF_W-1:0] r_perf_fetch;
  logic [PERF_W-1:0] r_perf_stall;

  // Free-running wrap-around performance counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_perf_fetch <= {PERF_W{1'b0}};
      r_perf_stall <= {PERF_W{1'b0}};
    end else begin
      if (w_inst_we) begin
        r_perf_fetch <= r_perf_fetch + {{(PERF_W-1){1'b0}}, 1'b1};
      end
      if ((r_state == WAIT_ARREADY) || (r_state == WAIT_RVALID)) begin
        r_perf_stall <= r_perf_stall + {{(PERF_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign perf_fetch_o = r_perf_fetch;
  assign perf_stall_o = r_perf_stall;
`else
  assign perf_fetch_o = {PERF_W{1'b0}};
  assign perf_stall_o = {PERF_W{1'b0}};
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl
//
// Directed bench for fetch_ctrl: hand-written sequences for reset, AR stall,
// asynchronous reset and counter wrap, plus a table of per-cycle vectors for
// the FSM walk. Inputs change 1 time unit after the rising edge; outputs are
// compared 2 time units after it.
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;

  localparam int PERF_W = 4;
`ifdef FETCH_PERF_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  logic              clock;
  logic              reset;
  logic              firing;
  logic [31:0]       pc_i;
  logic [31:0]       inst_i;
  logic              arvalid_o;
  logic              arready_i;
  logic [31:0]       araddr_o;
  logic              rvalid_i;
  logic              rready_o;
  logic [1:0]        rresp_i;
  logic              valid_o;
  logic              ready_i;
  logic              branch_valid_i;
  logic [2:0]        state_o;
  logic              pc_we_o;
  logic              inst_we_o;
  logic              bus_err_o;
  logic [PERF_W-1:0] perf_fetch_o;
  logic [PERF_W-1:0] perf_stall_o;

  fetch_ctrl #(.PERF_W(PERF_W)) dut (
    .clock          (clock),
    .reset          (reset),
    .firing         (firing),
    .pc_i           (pc_i),
    .inst_i         (inst_i),
    .arvalid_o      (arvalid_o),
    .arready_i      (arready_i),
    .araddr_o       (araddr_o),
    .rvalid_i       (rvalid_i),
    .rready_o       (rready_o),
    .rresp_i        (rresp_i),
    .valid_o        (valid_o),
    .ready_i        (ready_i),
    .branch_valid_i (branch_valid_i),
    .state_o        (state_o),
    .pc_we_o        (pc_we_o),
    .inst_we_o      (inst_we_o),
    .bus_err_o      (bus_err_o),
    .perf_fetch_o   (perf_fetch_o),
    .perf_stall_o   (perf_stall_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Advance to the next cycle and return all inputs to their quiet values.
  task automatic next_cycle();
    @(posedge clock);
    #1;
    firing         = 1'b0;
    arready_i      = 1'b0;
    rvalid_i       = 1'b0;
    rresp_i        = 2'b00;
    ready_i        = 1'b0;
    branch_valid_i = 1'b0;
    inst_i         = 32'h0000_0013;
  endtask

  task automatic do_reset();
    next_cycle();
    reset = 1'b0;
    #1;
    chk("reset_state", {29'd0, state_o}, 32'd0);
    chk("reset_strobes", {26'd0, arvalid_o, rready_o, valid_o, pc_we_o, inst_we_o, bus_err_o}, 32'd0);
    chk("reset_perf", {24'd0, perf_fetch_o, perf_stall_o}, 32'd0);
    next_cycle();
    reset = 1'b1;
  endtask

  typedef struct {
    logic        firing;
    logic        arready;
    logic        rvalid;
    logic [1:0]  rresp;
    logic        ready;
    logic        bvalid;
    logic [31:0] inst;
    logic [2:0]  exp_state;
    logic [5:0]  exp_out;  // {arvalid, rready, valid, pc_we, inst_we, bus_err}
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic f, input logic ar, input logic rv, input logic [1:0] rr,
                     input logic rd, input logic bv, input logic [31:0] ins,
                     input logic [2:0] st, input logic [5:0] o);
    vec_t v;
    v.firing = f;   v.arready = ar; v.rvalid = rv; v.rresp = rr;
    v.ready  = rd;  v.bvalid  = bv; v.inst   = ins;
    v.exp_state = st; v.exp_out = o;
    tbl.push_back(v);
  endtask

  initial begin
    reset          = 1'b1;
    firing         = 1'b0;
    pc_i           = 32'h8000_0000;
    inst_i         = 32'h0000_0013;
    arready_i      = 1'b0;
    rvalid_i       = 1'b0;
    rresp_i        = 2'b00;
    ready_i        = 1'b0;
    branch_valid_i = 1'b0;

    //       f  ar rv rresp  rd bv inst           state   out
    add(1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,32'h00000013,3'b000,6'b000000);
    add(1'b1,1'b0,1'b0,2'b00,1'b0,1'b0,32'h00000013,3'b000,6'b000000);
    add(1'b0,1'b1,1'b0,2'b00,1'b0,1'b0,32'h00000013,3'b010,6'b100000);
    add(1'b0,1'b0,1'b1,2'b00,1'b0,1'b0,32'h00000013,3'b011,6'b010010);
    add(1'b0,1'b0,1'b0,2'b00,1'b1,1'b0,32'h00000013,3'b001,6'b001100);
    add(1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,32'h00000013,3'b010,6'b100000);
    add(1'b0,1'b1,1'b0,2'b00,1'b0,1'b0,32'h00000013,3'b010,6'b100000);
    add(1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,32'h00000013,3'b011,6'b010000);
    add(1'b0,1'b0,1'b1,2'b00,1'b0,1'b0,32'h00000013,3'b011,6'b010010);
    add(1'b1,1'b0,1'b0,2'b00,1'b0,1'b0,32'h0000006F,3'b001,6'b001000);
    add(1'b0,1'b0,1'b0,2'b00,1'b1,1'b0,32'h0000006F,3'b001,6'b001000);
    add(1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,32'h00000013,3'b100,6'b000000);
    add(1'b0,1'b0,1'b0,2'b00,1'b0,1'b1,32'h00000013,3'b100,6'b000000);
    add(1'b0,1'b1,1'b0,2'b00,1'b0,1'b0,32'h00000013,3'b010,6'b100000);
    add(1'b0,1'b0,1'b1,2'b10,1'b0,1'b0,32'h00000013,3'b011,6'b010000);
    add(1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,32'h00000013,3'b000,6'b000001);
    add(1'b1,1'b0,1'b0,2'b00,1'b0,1'b0,32'h00000013,3'b000,6'b000001);
    add(1'b0,1'b1,1'b0,2'b00,1'b0,1'b1,32'h00000013,3'b010,6'b100001);
    add(1'b0,1'b0,1'b1,2'b00,1'b0,1'b0,32'h00000013,3'b011,6'b010011);
    add(1'b0,1'b0,1'b0,2'b00,1'b1,1'b0,32'h00000067,3'b001,6'b001001);
    add(1'b0,1'b0,1'b0,2'b00,1'b0,1'b1,32'h00000013,3'b100,6'b000001);
    add(1'b0,1'b1,1'b0,2'b00,1'b0,1'b0,32'h00000013,3'b010,6'b100001);
    add(1'b0,1'b0,1'b1,2'b00,1'b0,1'b0,32'h00000013,3'b011,6'b010011);
    add(1'b0,1'b0,1'b0,2'b00,1'b1,1'b0,32'h00000063,3'b001,6'b001001);
    add(1'b0,1'b0,1'b0,2'b00,1'b0,1'b1,32'h00000013,3'b100,6'b000001);
    add(1'b0,1'b1,1'b0,2'b00,1'b0,1'b0,32'h00000013,3'b010,6'b100001);
    add(1'b0,1'b0,1'b1,2'b01,1'b0,1'b0,32'h00000013,3'b011,6'b010001);
    add(1'b0,1'b1,1'b1,2'b00,1'b1,1'b1,32'h00000013,3'b000,6'b000001);
    add(1'b0,1'b1,1'b1,2'b00,1'b1,1'b1,32'h00000013,3'b000,6'b000001);

    // --- reset, then AR held off for 5 cycles -------------------------------
    do_reset();
    next_cycle();
    firing = 1'b1;
    #1;
    chk("fire_idle_state", {29'd0, state_o}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      #1;
      chk($sformatf("stall%0d_arvalid", i), {31'd0, arvalid_o}, 32'd1);
      chk($sformatf("stall%0d_araddr", i), araddr_o, 32'h8000_0000);
    end
    next_cycle();
    arready_i = 1'b1;
    #1;
    chk("stall_accept_state", {29'd0, state_o}, 32'd2);
    next_cycle();
    #1;
    chk("stall_perf", {28'd0, perf_stall_o}, PERF_ON ? 32'd6 : 32'd0);
    chk("rvalid_state", {29'd0, state_o}, 32'd3);
    chk("rvalid_rready", {31'd0, rready_o}, 32'd1);

    // --- asynchronous reset in WAIT_RVALID, mid-cycle ------------------------
    reset = 1'b0;
    #1;
    chk("async_rst_rready", {31'd0, rready_o}, 32'd0);
    chk("async_rst_state", {29'd0, state_o}, 32'd0);
    chk("async_rst_perf", {28'd0, perf_stall_o}, 32'd0);
    next_cycle();
    reset = 1'b1;

    // --- table-driven FSM walk ---------------------------------------------
    foreach (tbl[i]) begin
      next_cycle();
      firing         = tbl[i].firing;
      arready_i      = tbl[i].arready;
      rvalid_i       = tbl[i].rvalid;
      rresp_i        = tbl[i].rresp;
      ready_i        = tbl[i].ready;
      branch_valid_i = tbl[i].bvalid;
      inst_i         = tbl[i].inst;
      #1;
      chk($sformatf("row%0d", i),
          {23'd0, state_o, arvalid_o, rready_o, valid_o, pc_we_o, inst_we_o, bus_err_o},
          {23'd0, tbl[i].exp_state, tbl[i].exp_out});
    end

    // --- 16 zero-wait fetches: counter wrap ----------------------------------
    do_reset();
    next_cycle();
    firing = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      next_cycle();
      arready_i = 1'b1;
      next_cycle();
      rvalid_i = 1'b1;
      next_cycle();
      ready_i = 1'b1;
      #1;
      chk($sformatf("wrap%0d_valid", k), {29'd0, state_o, valid_o} , {29'd0, 3'b001, 1'b1});
      chk($sformatf("wrap%0d_fetch", k), {28'd0, perf_fetch_o}, PERF_ON ? (k % 16) : 32'd0);
      chk($sformatf("wrap%0d_stall", k), {28'd0, perf_stall_o}, PERF_ON ? ((2 * k) % 16) : 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
